// File: rtl/reg_dump_tx.sv
// reg_dump_tx
//
// Captures a snapshot of the flattened register-file bus on request and
// streams it out one byte at a time over a valid/ready interface feeding the
// debug UART transmitter. Register 0 goes first, and each register is sent
// most-significant byte first.
//
// Optional feature (compile-time macro REG_DUMP_CHECKSUM_EN):
//   When defined, an 8-bit XOR of every data byte is appended as one extra
//   byte after the last data byte. When undefined, no checksum logic exists.
//
// Parameters:
//   N_REGS       number of registers in the snapshot
//   DATA_W       register width in bits (multiple of 8)
//
// Ports:
//   clk          system clock, rising edge
//   i_reset      asynchronous active-high reset; aborts a dump in progress
//   i_start      dump request, only looked at while idle
//   i_registers  flattened register bus; register i at [DATA_W*i +: DATA_W]
//   o_tx_data    byte being offered to the transmitter
//   o_tx_valid   o_tx_data holds a valid byte
//   i_tx_ready   transmitter takes the byte on this edge when o_tx_valid=1
//   o_busy       dump in progress (SEND and DONE)
//   o_done       one-cycle pulse after the final byte is accepted
module reg_dump_tx #(
  parameter int N_REGS = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [N_REGS*DATA_W-1:0] i_registers,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int BPR    = DATA_W / 8;
  localparam int NBYTES = N_REGS * BPR;
  localparam int IDX_W  = $clog2(NBYTES + 1);

`ifdef REG_DUMP_CHECKSUM_EN
  // The checksum occupies one extra slot after the data bytes.
  localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
`endif

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [IDX_W-1:0]           idx_reg, idx_next;
  logic [N_REGS*DATA_W-1:0]   shadow_reg;
  logic [7:0]                 tx_data_reg, tx_data_next;
  logic                       tx_valid_reg, tx_valid_next;
  logic                       busy_reg, busy_next;
  logic                       done_reg, done_next;
  logic                       capture;
  logic                       accept;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]                 acc_reg, acc_next;
`endif

  // Stream byte k: register k/BPR, byte (BPR-1 - k%BPR) counting the LSB as 0.
  function automatic logic [7:0] byte_at(input logic [N_REGS*DATA_W-1:0] snap,
                                         input logic [IDX_W-1:0] k);
    int reg_i;
    int byte_i;
    reg_i  = int'(k) / BPR;
    byte_i = BPR - 1 - (int'(k) % BPR);
    return snap[DATA_W*reg_i + 8*byte_i +: 8];
  endfunction

  assign capture = (state_reg == IDLE) && i_start;
  assign accept  = (state_reg == SEND) && i_tx_ready;

  // State and datapath registers.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      shadow_reg   <= '0;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_reg      <= 8'h00;
`endif
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      if (capture) begin
        shadow_reg <= i_registers;
      end
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_reg      <= acc_next;
`endif
    end
  end

  // Next-state and byte index.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        if (i_tx_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // While SEND is active, tx_data_reg is exactly the byte being offered, so
  // folding it in on acceptance accumulates every transmitted data byte.
  always_comb begin
    acc_next = acc_reg;
    if (capture) begin
      acc_next = 8'h00;
    end else if (accept && (idx_reg != CSUM_IDX)) begin
      acc_next = acc_reg ^ tx_data_reg;
    end
  end
`endif

  // Registered outputs are computed from the upcoming state, so the first
  // byte is visible the cycle after the start edge.
  always_comb begin
    busy_next     = (state_next != IDLE);
    tx_valid_next = (state_next == SEND);
    done_next     = (state_next == DONE);
    tx_data_next  = 8'h00;
    if (state_next == SEND) begin
      if (capture) begin
        // Shadow is loaded on this same edge; take byte 0 from the live bus.
        tx_data_next = byte_at(i_registers, '0);
`ifdef REG_DUMP_CHECKSUM_EN
      end else if (idx_next == CSUM_IDX) begin
        tx_data_next = acc_next;
`endif
      end else begin
        tx_data_next = byte_at(shadow_reg, idx_next);
      end
    end
  end

  assign o_tx_data  = tx_data_reg;
  assign o_tx_valid = tx_valid_reg;
  assign o_busy     = busy_reg;
  assign o_done     = done_reg;

endmodule

// File: tb/tb_reg_dump_tx.sv
module tb_reg_dump_tx;

  localparam int N_REGS = 32;
  localparam int DATA_W = 32;
  localparam int NW     = N_REGS * DATA_W;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [NW-1:0] i_registers;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic          o_busy;
  logic          o_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    int         reg_idx;
    logic [31:0] value;
    int         k;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  reg_dump_tx #(.N_REGS(N_REGS), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_registers(i_registers),
    .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected stream: registers in ascending order, each MSB byte first,
  // optionally followed by the XOR of all data bytes.
  task automatic build_model(input logic [NW-1:0] regs);
    logic [7:0] cs;
    logic [31:0] word;
    cs = 8'h00;
    exp_q.delete();
    for (int r = 0; r < N_REGS; r++) begin
      word = regs[32*r +: 32];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(word[8*b +: 8]);
        cs = cs ^ word[8*b +: 8];
      end
    end
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  // ready_mode: 0 always ready, 1 toggling 1-0-1-0, 2 random.
  // abort_at >= 0 asserts reset once that many bytes have been accepted.
  task automatic run_dump(input string tag, input logic [NW-1:0] regs,
                          input int ready_mode, input bit change_regs,
                          input bit start_mid, input int abort_at);
    int busy_cnt;
    int valid_cnt;
    bit ready;
    bit prev_stall;
    bit finished;
    logic [7:0] prev_data;
    build_model(regs);
    got_q.delete();
    busy_cnt = 0;
    valid_cnt = 0;
    prev_stall = 0;
    prev_data = 8'h00;
    finished = 0;
    @(negedge clk);
    i_registers = regs;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, " first_valid"}, int'(o_tx_valid), 1);
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (change_regs && cyc == 0) i_registers = '1;
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        i_reset = 1'b1;
        #1;
        check({tag, " abort_valid"}, int'(o_tx_valid), 0);
        check({tag, " abort_busy"}, int'(o_busy), 0);
        check({tag, " abort_done"}, int'(o_done), 0);
        @(negedge clk);
        check({tag, " abort_no_done"}, int'(o_done), 0);
        i_reset = 1'b0;
        i_tx_ready = 1'b1;
        @(negedge clk);
        check({tag, " abort_idle_valid"}, int'(o_tx_valid), 0);
        check({tag, " abort_idle_done"}, int'(o_done), 0);
        $display("dump %s aborted after %0d bytes", tag, got_q.size());
        return;
      end
      if (o_busy) busy_cnt++;
      if (o_tx_valid) valid_cnt++;
      if (prev_stall) begin
        check({tag, " stall_valid"}, int'(o_tx_valid), 1);
        check({tag, " stall_data"}, int'(o_tx_data), int'(prev_data));
      end
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 2 == 0);
        default: ready = $urandom_range(1, 0) == 1;
      endcase
      i_tx_ready = ready;
      i_start = start_mid && (cyc == 10);
      if (o_done) begin
        check({tag, " done_after_last"}, got_q.size(), exp_q.size());
        check({tag, " done_valid_low"}, int'(o_tx_valid), 0);
        check({tag, " done_busy"}, int'(o_busy), 1);
        i_start = start_mid;
        @(negedge clk);
        i_start = 1'b0;
        check({tag, " idle_busy"}, int'(o_busy), 0);
        check({tag, " idle_valid"}, int'(o_tx_valid), 0);
        check({tag, " single_done"}, int'(o_done), 0);
        finished = 1;
      end else begin
        if (o_tx_valid && ready) got_q.push_back(o_tx_data);
        prev_stall = o_tx_valid && !ready;
        prev_data = o_tx_data;
        @(negedge clk);
      end
    end
    if (!finished) check({tag, " timeout"}, 0, 1);
    check({tag, " byte_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s byte%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
    end
    if (ready_mode == 0) begin
      check({tag, " busy_cycles"}, busy_cnt, exp_q.size() + 1);
      check({tag, " valid_cycles"}, valid_cnt, exp_q.size());
    end
    $display("dump %s: %0d bytes, %0d busy cycles", tag, got_q.size(), busy_cnt);
  endtask

  initial begin
    logic [NW-1:0] regs;
    logic [NW-1:0] pat;

    i_reset = 1'b1;
    i_start = 1'b0;
    i_tx_ready = 1'b0;
    i_registers = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_data", int'(o_tx_data), 0);
    check("reset_valid", int'(o_tx_valid), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_done", int'(o_done), 0);
    i_reset = 1'b0;
    i_tx_ready = 1'b1;
    @(negedge clk);
    check("idle_ready_no_effect", int'(o_tx_valid), 0);

    // Test 1: incrementing pattern, always ready.
    for (int r = 0; r < N_REGS; r++) pat[32*r +: 32] = {4{8'(r)}};
    run_dump("incr", pat, 0, 0, 0, -1);

    // Test 2: DEADBEEF in register 1 with toggling ready.
    regs = '0;
    regs[63:32] = 32'hDEADBEEF;
    run_dump("toggle", regs, 1, 0, 0, -1);

    // Test 3: bus changes after capture.
    run_dump("snapshot", pat, 0, 1, 0, -1);

    // Test 4: start pulses in SEND and DONE, then a fresh dump.
    run_dump("start_ignored", pat, 0, 0, 1, -1);
    run_dump("fresh", regs, 0, 0, 0, -1);

    // Test 5: reset after byte 50, then a full dump from byte 0.
    run_dump("abort", pat, 0, 0, 0, 50);
    run_dump("after_abort", pat, 0, 0, 0, -1);

    // Table: single non-zero register, spot-check stream positions.
    tbl.push_back('{1,  32'hDEADBEEF, 4,   8'hDE});
    tbl.push_back('{1,  32'hDEADBEEF, 5,   8'hAD});
    tbl.push_back('{1,  32'hDEADBEEF, 7,   8'hEF});
    tbl.push_back('{31, 32'h12345678, 124, 8'h12});
    tbl.push_back('{31, 32'h12345678, 127, 8'h78});
    tbl.push_back('{0,  32'hA5C30000, 0,   8'hA5});
    tbl.push_back('{0,  32'hA5C30000, 3,   8'h00});
`ifdef REG_DUMP_CHECKSUM_EN
    tbl.push_back('{1,  32'hDEADBEEF, 128, 8'h22});
`endif
    for (int t = 0; t < tbl.size(); t++) begin
      regs = '0;
      regs[32*tbl[t].reg_idx +: 32] = tbl[t].value;
      run_dump($sformatf("tbl%0d", t), regs, 0, 0, 0, -1);
      if (tbl[t].k < got_q.size())
        check($sformatf("tbl%0d k%0d", t, tbl[t].k), int'(got_q[tbl[t].k]), int'(tbl[t].exp));
      else
        check($sformatf("tbl%0d k%0d missing", t, tbl[t].k), got_q.size(), tbl[t].k + 1);
    end

    // Randomized registers with random ready.
    for (int n = 0; n < 4; n++) begin
      for (int r = 0; r < N_REGS; r++) regs[32*r +: 32] = $urandom;
      run_dump($sformatf("rand%0d", n), regs, 2, 0, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
